line_parity_solver: RTL and testbench

LINE_PARITY_SOLVER -- requirements
Module: line_parity_solver

---
 rtl/line_parity_solver.sv | 172 +++++++++++++++++
 tb/tb_line_parity_solver.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/line_parity_solver.sv
`default_nettype none
// ============================================================================
// line_parity_solver
// Brute-force search for the smallest button subset whose XOR matches the
// parity pattern of a line's joltages; accumulates the minima into a total.
// Revision: 1.0
// ============================================================================
module line_parity_solver #(
    parameter int MACHINE_COUNT    = 10,
    parameter int MAX_BUTTON_COUNT = 13,
    parameter int BITS_PER_JOLTAGE = 9,
    parameter int TOTAL_WIDTH      = 32
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      new_line_given,
    input  logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]     button_count,
    input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] flattened_buttons,
    input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] flattened_machines,
    output logic                                      busy,
    output logic                                      result_valid,
    output logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]     min_presses,
    output logic                                      no_solution,
    output logic [TOTAL_WIDTH-1:0]                    total,
    output logic                                      overrun
);

    localparam int CW = $clog2(MAX_BUTTON_COUNT + 1);
    localparam int SW = MAX_BUTTON_COUNT + 1;
    localparam int BW = MACHINE_COUNT * MAX_BUTTON_COUNT;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [BW-1:0]            buttons_q, buttons_d;
    logic [MACHINE_COUNT-1:0] target_q, target_d;
    logic [CW-1:0]            n_q, n_d;
    logic [SW-1:0]            s_q, s_d;
    logic [CW-1:0]            best_q, best_d;
    logic                     found_q, found_d;
    logic [CW-1:0]            min_presses_q, min_presses_d;
    logic                     no_solution_q, no_solution_d;
    logic [TOTAL_WIDTH-1:0]   total_q, total_d;
    logic                     overrun_q, overrun_d;

    logic [MACHINE_COUNT-1:0] w_target_in;
    logic [CW-1:0]            w_n_in;
    logic [MACHINE_COUNT-1:0] w_xor;
    logic [CW-1:0]            w_pop;
    logic [SW-1:0]            w_last_s;
    logic                     w_last;
    logic                     w_better;
    logic [CW-1:0]            w_best;
    logic                     w_found;

    // Only the parity bit of each joltage matters to the search.
    always_comb begin
        w_target_in = '0;
        for (int m = 0; m < MACHINE_COUNT; m++) begin
            w_target_in[m] = flattened_machines[m*BITS_PER_JOLTAGE];
        end
        w_n_in = (button_count > CW'(MAX_BUTTON_COUNT)) ? CW'(MAX_BUTTON_COUNT) : button_count;
    end

    always_comb begin
        w_xor = '0;
        w_pop = '0;
        for (int i = 0; i < MAX_BUTTON_COUNT; i++) begin
            if (s_q[i] && (i < int'(n_q))) begin
                w_xor = w_xor ^ buttons_q[i*MACHINE_COUNT +: MACHINE_COUNT];
            end
        end
        for (int i = 0; i < SW; i++) begin
            w_pop = w_pop + CW'(s_q[i]);
        end
        w_last_s = (SW'(1) << n_q) - SW'(1);
        w_last   = (s_q == w_last_s);
        w_better = (w_xor == target_q) && (w_pop < best_q);
        w_best   = w_better ? w_pop : best_q;
        w_found  = found_q | w_better;
    end

    always_comb begin
        state_d       = state_q;
        buttons_d     = buttons_q;
        target_d      = target_q;
        n_d           = n_q;
        s_d           = s_q;
        best_d        = best_q;
        found_d       = found_q;
        min_presses_d = min_presses_q;
        no_solution_d = no_solution_q;
        total_d       = total_q;
        overrun_d     = overrun_q | (new_line_given && (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (new_line_given) begin
                    buttons_d = flattened_buttons;
                    target_d  = w_target_in;
                    n_d       = w_n_in;
                    s_d       = '0;
                    best_d    = '1;
                    found_d   = 1'b0;
                    state_d   = SEARCH;
                end
            end
            SEARCH: begin
                s_d     = s_q + SW'(1);
                best_d  = w_best;
                found_d = w_found;
                // Results are registered on the last evaluation so they are
                // already stable during the DONE cycle that flags them.
                if (w_last) begin
                    state_d       = DONE;
                    min_presses_d = w_found ? w_best : '0;
                    no_solution_d = ~w_found;
                    if (w_found) begin
                        total_d = total_q + TOTAL_WIDTH'(w_best);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            buttons_q     <= '0;
            target_q      <= '0;
            n_q           <= '0;
            s_q           <= '0;
            best_q        <= '1;
            found_q       <= 1'b0;
            min_presses_q <= '0;
            no_solution_q <= 1'b0;
            total_q       <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            buttons_q     <= buttons_d;
            target_q      <= target_d;
            n_q           <= n_d;
            s_q           <= s_d;
            best_q        <= best_d;
            found_q       <= found_d;
            min_presses_q <= min_presses_d;
            no_solution_q <= no_solution_d;
            total_q       <= total_d;
            overrun_q     <= overrun_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE);
    assign min_presses  = min_presses_q;
    assign no_solution  = no_solution_q;
    assign total        = total_q;
    assign overrun      = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_line_parity_solver.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_line_parity_solver
// Directed vectors with a result scoreboard for line_parity_solver.
// Revision: 1.0
// ============================================================================
module tb_line_parity_solver;

    localparam int MC  = 10;
    localparam int MB  = 13;
    localparam int BPJ = 9;
    localparam int TW  = 4;
    localparam int CW  = $clog2(MB + 1);

    typedef struct {
        int            cyc;
        logic [CW-1:0] mp;
        logic          ns;
        logic [TW-1:0] tot;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   new_line_given = 1'b0;
    logic [CW-1:0]          button_count = '0;
    logic [MB-1:0][MC-1:0]  btn = '0;
    logic [MC-1:0][BPJ-1:0] jolt = '0;
    logic                   busy;
    logic                   result_valid;
    logic [CW-1:0]          min_presses;
    logic                   no_solution;
    logic [TW-1:0]          total;
    logic                   overrun;

    exp_t exp_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   cyc       = 0;
    int   exp_total = 0;

    line_parity_solver #(
        .MACHINE_COUNT   (MC),
        .MAX_BUTTON_COUNT(MB),
        .BITS_PER_JOLTAGE(BPJ),
        .TOTAL_WIDTH     (TW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .new_line_given    (new_line_given),
        .button_count      (button_count),
        .flattened_buttons (btn),
        .flattened_machines(jolt),
        .busy              (busy),
        .result_valid      (result_valid),
        .min_presses       (min_presses),
        .no_solution       (no_solution),
        .total             (total),
        .overrun           (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (reset && result_valid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_result_valid", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("latency_cycle", cyc, e.cyc);
                chk("min_presses", min_presses, e.mp);
                chk("no_solution", no_solution, e.ns);
                chk("total", total, e.tot);
            end
        end
    end

    // Issue a line; the pulse is high during cycle k, result due at k+2^N+1.
    task automatic start_line(input int bc, input logic [MB-1:0][MC-1:0] b,
                              input logic [MC-1:0][BPJ-1:0] j, input int n_eff,
                              input int emin, input bit ens);
        exp_t e;
        @(posedge clk); #1;
        button_count   = CW'(bc);
        btn            = b;
        jolt           = j;
        new_line_given = 1'b1;
        if (!ens) exp_total = (exp_total + emin) % (1 << TW);
        e.cyc = cyc + (1 << n_eff) + 1;
        e.mp  = ens ? '0 : CW'(emin);
        e.ns  = ens;
        e.tot = TW'(exp_total);
        exp_q.push_back(e);
        @(posedge clk); #1;
        new_line_given = 1'b0;
    endtask

    task automatic finish_line(input int n_eff);
        repeat ((1 << n_eff) + 1) @(posedge clk);
        #1;
        chk("busy_after_line", busy, 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_min_presses"}, min_presses, 0);
        chk({tag, "_no_solution"}, no_solution, 0);
        chk({tag, "_total"}, total, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        logic [MB-1:0][MC-1:0]  ba, b3, b;
        logic [MC-1:0][BPJ-1:0] ja, j3, j;

        ba = '0; ba[0] = 10'h003; ba[1] = 10'h006; ba[2] = 10'h004;
        ja = '0; ja[0] = 9'd1; ja[2] = 9'd1;
        b3 = '0; b3[0] = 10'h001; b3[1] = 10'h002; b3[2] = 10'h004;
        j3 = '0; j3[0] = 9'd1; j3[1] = 9'd1; j3[2] = 9'd3;

        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        reset = 1'b1;

        // Target 0x005 reached by b0^b1 (2 presses).
        start_line(3, ba, ja, 3, 2, 1'b0);
        finish_line(3);

        // Single button 0x001 can never produce 0x002.
        b = '0; b[0] = 10'h001; j = '0; j[1] = 9'd1;
        start_line(1, b, j, 1, 0, 1'b1);
        finish_line(1);

        // N=0 with even joltages: empty subset solves it.
        b = '0; j = '0; j[0] = 9'd2; j[5] = 9'd4;
        start_line(0, b, j, 0, 0, 1'b0);
        finish_line(0);

        // N=0 with an odd joltage: unsolvable.
        b = '0; j = '0; j[0] = 9'd3;
        start_line(0, b, j, 0, 0, 1'b1);
        finish_line(0);

        // All three buttons needed for 0x007.
        start_line(3, b3, j3, 3, 3, 1'b0);
        finish_line(3);

        // Button 3 alone equals target 0x007.
        b = b3; b[3] = 10'h007;
        start_line(4, b, j3, 4, 1, 1'b0);
        finish_line(4);

        // Count above the maximum is clamped to 13 buttons.
        b = '0; b[12] = 10'h200; j = '0; j[9] = 9'd1;
        start_line(15, b, j, MB, 1, 1'b0);
        finish_line(MB);

        // Start pulse and input changes during a search are ignored.
        start_line(3, ba, ja, 3, 2, 1'b0);
        @(posedge clk); #1;
        new_line_given = 1'b1;
        button_count   = '0;
        btn            = '0;
        jolt           = '0;
        @(posedge clk); #1;
        new_line_given = 1'b0;
        chk("overrun_set", overrun, 1);
        chk("busy_during_overrun", busy, 1);
        repeat (7) @(posedge clk);
        #1;
        chk("busy_after_overrun_line", busy, 0);
        chk("overrun_sticky", overrun, 1);

        start_line(3, b3, j3, 3, 3, 1'b0);
        finish_line(3);
        start_line(3, ba, ja, 3, 2, 1'b0);
        finish_line(3);
        chk("total_before_wrap", total, 14);
        start_line(3, b3, j3, 3, 3, 1'b0);
        finish_line(3);
        chk("total_after_wrap", total, 1);

        // Reset in the middle of a search aborts the line.
        start_line(3, ba, ja, 3, 2, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete(exp_q.size() - 1);
        exp_total = 0;
        #1;
        check_zero_outputs("midreset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        chk("idle_after_abort", busy, 0);

        start_line(3, ba, ja, 3, 2, 1'b0);
        finish_line(3);

        chk("pending_results", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_timeout actual=%0d required=0", cyc);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
